// File: rtl/controlador_microbots_pkg.sv
// Shared encodings and constants for the microbot motor controller.
package controlador_pkg;

  localparam int unsigned PWM_W      = 4;
  localparam logic [7:0]  UIO_OE_VAL = 8'hF0;
  localparam logic [3:0]  SPEED_RST  = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FWD     = 3'd1,
    ST_BWD     = 3'd2,
    ST_LEFT    = 3'd3,
    ST_RIGHT   = 3'd4,
    ST_BLOCKED = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_STOP      = 3'd0,
    OP_FWD       = 3'd1,
    OP_BWD       = 3'd2,
    OP_LEFT      = 3'd3,
    OP_RIGHT     = 3'd4,
    OP_SET_SPEED = 3'd5,
    OP_NOP6      = 3'd6,
    OP_NOP7      = 3'd7
  } opcode_t;

  function automatic logic is_moving(input state_t s);
    return (s == ST_FWD) || (s == ST_BWD) || (s == ST_LEFT) || (s == ST_RIGHT);
  endfunction

endpackage

// File: rtl/controlador_microbots_pwm_gen.sv
// Shared 16-step PWM counter driving the left and right wheel comparators.
module pwm_gen
  import controlador_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [PWM_W-1:0] speed,
  input  logic             en_l,
  input  logic             en_r,
  output logic             pwm_l,
  output logic             pwm_r
);

  logic [PWM_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena) begin
      cnt <= cnt + PWM_W'(1);
    end
  end

  assign pwm_l = ena & en_l & (cnt < speed);
  assign pwm_r = ena & en_r & (cnt < speed);

endmodule

// File: rtl/controlador_microbots.sv
// Microbot top: command decode FSM, bumper synchronisers, movement watchdog.
module controlador_microbots
  import controlador_pkg::*;
#(
  parameter int unsigned WDT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0]       ui_q;
  logic             strobe_prev;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  state_t           state;
  logic [PWM_W-1:0] speed;
  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_trip;

  logic    accept;
  opcode_t op;
  logic    front_s;
  logic    rear_s;
  logic    moving;
  logic    wdt_done;
  logic    dir_l;
  logic    dir_r;
  logic    pwm_l;
  logic    pwm_r;
  logic    unused_uio;

  assign accept     = ui_q[7] & ~strobe_prev;
  assign op         = opcode_t'(ui_q[2:0]);
  assign front_s    = sync2[0];
  assign rear_s     = sync2[1];
  assign moving     = is_moving(state);
  assign wdt_done   = (wdt_cnt == '1);
  assign unused_uio = ^uio_in[7:2];

  // Priority: bumper block, then watchdog, then the accepted command.
  // wdt_trip clear on accept sits first so a simultaneous trip still wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ui_q        <= '0;
      strobe_prev <= 1'b0;
      sync1       <= '0;
      sync2       <= '0;
      state       <= ST_IDLE;
      speed       <= SPEED_RST;
      wdt_cnt     <= '0;
      wdt_trip    <= 1'b0;
    end else begin
      ui_q        <= ui_in;
      strobe_prev <= ui_q[7];
      sync1       <= uio_in[1:0];
      sync2       <= sync1;

      if (!moving || accept) wdt_cnt <= '0;
      else                   wdt_cnt <= wdt_cnt + WDT_W'(1);

      if (accept) wdt_trip <= 1'b0;

      if ((state == ST_FWD && front_s) || (state == ST_BWD && rear_s)) begin
        state <= ST_BLOCKED;
      end else if (moving && wdt_done) begin
        state    <= ST_IDLE;
        wdt_trip <= 1'b1;
      end else if (accept) begin
        if (state == ST_BLOCKED) begin
          if (op == OP_STOP) state <= ST_IDLE;
        end else begin
          case (op)
            OP_STOP:      state <= ST_IDLE;
            OP_FWD:       state <= front_s ? ST_BLOCKED : ST_FWD;
            OP_BWD:       state <= rear_s ? ST_BLOCKED : ST_BWD;
            OP_LEFT:      state <= ST_LEFT;
            OP_RIGHT:     state <= ST_RIGHT;
            OP_SET_SPEED: speed <= ui_q[6:3];
            default:      ;
          endcase
        end
      end
    end
  end

  always_comb begin
    dir_l = 1'b0;
    dir_r = 1'b0;
    case (state)
      ST_FWD:   begin dir_l = 1'b1; dir_r = 1'b1; end
      ST_LEFT:  dir_r = 1'b1;
      ST_RIGHT: dir_l = 1'b1;
      default:  ;
    endcase
  end

  pwm_gen u_pwm (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .speed (speed),
    .en_l  (moving),
    .en_r  (moving),
    .pwm_l (pwm_l),
    .pwm_r (pwm_r)
  );

  assign uo_out  = {state, moving, dir_r, pwm_r, dir_l, pwm_l};
  assign uio_out = {(state == ST_BLOCKED), wdt_trip, rear_s, front_s, 4'b0000};
  assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_controlador_microbots.sv
// Scoreboard bench for controlador_microbots: stimulus queues expectations, a monitor checks them.
module tb_controlador_microbots;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  controlador_microbots #(.WDT_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         duty;
    logic [7:0] mask_uo;
    logic [7:0] exp_uo;
    logic [7:0] mask_uio;
    logic [7:0] exp_uio;
    int         exp_cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin : mon
        exp_t e;
        int   cl;
        int   cr;
        e = sb.pop_front();
        total++;
        if (e.duty) begin
          cl = 0;
          cr = 0;
          for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            if (uo_out[0] === 1'b1) cl++;
            if (uo_out[2] === 1'b1) cr++;
          end
          if (cl != e.exp_cnt || cr != e.exp_cnt) begin
            bad++;
            $display("FAIL %s: pwm_l high=%0d pwm_r high=%0d of 16, required %0d",
                     e.name, cl, cr, e.exp_cnt);
          end
        end else begin
          if ((uo_out & e.mask_uo) !== e.exp_uo || (uio_out & e.mask_uio) !== e.exp_uio ||
              uio_oe !== 8'hF0) begin
            bad++;
            $display("FAIL %s: uo_out=%h (mask %h) required %h, uio_out=%h (mask %h) required %h, uio_oe=%h required f0",
                     e.name, uo_out, e.mask_uo, e.exp_uo, uio_out, e.mask_uio, e.exp_uio, uio_oe);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] mu, input logic [7:0] eu,
                     input logic [7:0] mio, input logic [7:0] eio);
    exp_t e;
    e.name = name; e.duty = 1'b0; e.exp_cnt = 0;
    e.mask_uo = mu; e.exp_uo = eu; e.mask_uio = mio; e.exp_uio = eio;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic chk_duty(input string name, input int cnt);
    exp_t e;
    e.name = name; e.duty = 1'b1; e.exp_cnt = cnt;
    e.mask_uo = 8'h00; e.exp_uo = 8'h00; e.mask_uio = 8'h00; e.exp_uio = 8'h00;
    sb.push_back(e);
    repeat (16) @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] cmd);
    ui_in = cmd | 8'h80;
    tick(1);
    ui_in = cmd & 8'h7F;
    tick(1);
  endtask

  initial begin
    tick(3);
    chk("reset_held", 8'hFF, 8'h00, 8'hFF, 8'h00);
    rst_n = 1'b1;
    tick(2);
    chk("reset_state", 8'hFF, 8'h00, 8'hFF, 8'h00);

    // FWD with latency check: state changes on the second edge after strobe rise
    ui_in = 8'h81;
    tick(1);
    chk("fwd_latency", 8'hE0, 8'h00, 8'h00, 8'h00);
    ui_in = 8'h01;
    tick(1);
    chk("fwd_state", 8'hFA, 8'h3A, 8'hFF, 8'h00);
    chk_duty("duty_8", 8);

    send(8'hFD);
    chk("speed15_state", 8'hFA, 8'h3A, 8'hFF, 8'h00);
    chk_duty("duty_15", 15);
    send(8'h85);
    chk("speed0_moving", 8'hFF, 8'h3A, 8'hFF, 8'h00);
    chk_duty("duty_0", 0);
    send(8'hC5);

    // Front bumper while moving forward
    uio_in = 8'h01;
    tick(2);
    chk("bump_sync_delay", 8'hE0, 8'h20, 8'h00, 8'h00);
    tick(1);
    chk("bump_blocked", 8'hFF, 8'hA0, 8'hFF, 8'h90);
    send(8'h01);
    chk("blocked_fwd_ign", 8'hFF, 8'hA0, 8'hFF, 8'h90);
    send(8'h9D);
    chk("blocked_spd_ign", 8'hFF, 8'hA0, 8'hFF, 8'h90);
    send(8'h00);
    chk("blocked_stop", 8'hFF, 8'h00, 8'hFF, 8'h10);
    send(8'h01);
    chk("fwd_into_bumper", 8'hFF, 8'hA0, 8'hFF, 8'h90);
    uio_in = 8'h00;
    tick(2);
    send(8'h00);
    chk("clear_stop", 8'hFF, 8'h00, 8'hFF, 8'h00);
    send(8'h01);
    chk_duty("speed_kept_8", 8);

    // Rear bumper while reversing
    send(8'h02);
    chk("bwd_state", 8'hFA, 8'h50, 8'hFF, 8'h00);
    uio_in = 8'h02;
    tick(3);
    chk("rear_blocked", 8'hFF, 8'hA0, 8'hFF, 8'hA0);
    uio_in = 8'h00;
    tick(2);
    send(8'h00);

    // Strobe held high while opcode changes: only the first is taken
    ui_in = 8'h83;
    tick(2);
    chk("hold_left", 8'hFA, 8'h78, 8'hFF, 8'h00);
    ui_in = 8'h84;
    tick(8);
    chk("hold_single", 8'hFA, 8'h78, 8'hFF, 8'h00);
    ui_in = 8'h00;
    tick(2);

    ena = 1'b0;
    chk("ena0_state", 8'hFF, 8'h78, 8'hFF, 8'h00);
    chk_duty("ena0_duty", 0);
    ena = 1'b1;
    tick(1);

    // Watchdog
    send(8'h01);
    tick(65530);
    chk("wdt_not_yet", 8'hE0, 8'h20, 8'h40, 8'h00);
    tick(10);
    chk("wdt_trip", 8'hFF, 8'h00, 8'hFF, 8'h40);
    send(8'h06);
    chk("wdt_clear", 8'hFF, 8'h00, 8'hFF, 8'h00);

    // Asynchronous reset mid-RIGHT
    send(8'h95);
    send(8'h04);
    chk("right_state", 8'hFA, 8'h92, 8'hFF, 8'h00);
    chk_duty("duty_2", 2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    chk("rst_async", 8'hFF, 8'h00, 8'hFF, 8'h00);
    rst_n = 1'b1;
    tick(1);
    send(8'h01);
    chk_duty("speed_reset_8", 8);

    tick(2);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: pending=%0d required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
